// File: rtl/ff_bank_arbiter_if.sv
// Requester-side bus of the flop-bank arbiter: packed per-requester
// request/op/address/data lanes plus the shared grant/ack/response signals.
interface ff_bank_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int AW    = 4
);
    logic [N_REQ-1:0]    req;
    logic [N_REQ-1:0]    wr;
    logic [N_REQ*AW-1:0] addr;
    logic [N_REQ*DW-1:0] wdata;
    logic [N_REQ-1:0]    gnt;
    logic [N_REQ-1:0]    ack;
    logic                err;
    logic [DW-1:0]       rdata;

    modport master (output req, wr, addr, wdata, input gnt, ack, err, rdata);
    modport slave  (input req, wr, addr, wdata, output gnt, ack, err, rdata);
endinterface

// File: rtl/ff_bank_arbiter.sv
// Round-robin controller sharing one write/read path of a DEPTH x DW flop bank
// among N_REQ requesters; also sequences a whole-bank synchronous clear.
//
// state  | meaning
// IDLE   | waiting; a clear request beats pending accesses
// ACCESS | winner granted; bank loads (write) or is sampled (read)
// RESP   | ack pulse with err/rdata; round-robin pointer moves to winner
// CLEAR  | one-cycle synchronous clear of every bank register
module ff_bank_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 12,
    parameter int AW    = 4
) (
    input  logic                clk,
    input  logic                rst,
    ff_bank_arbiter_if.slave    bus,
    input  logic                clr_req,
    output logic                clr_ack,
    output logic                busy,
    output logic [DEPTH-1:0]    ff_en,
    output logic [DW-1:0]       ff_d,
    output logic                ff_clr,
    input  logic [DEPTH*DW-1:0] ff_q
);
    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP, CLEAR} state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, rr_ptr_q, pick;
    logic          found;
    int            cand;
    logic          wr_q, err_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, rdata_q, rd_sel;
    logic          in_range;
    logic          pick_wr;
    logic [AW-1:0] pick_addr;
    logic [DW-1:0] pick_wdata;

    // Extra top bit keeps the compare correct when DEPTH == 2**AW.
    assign in_range  = ({1'b0, addr_q} < (AW + 1)'(DEPTH));
    assign bus.rdata = rdata_q;

    // Round-robin search starting just past the last served requester.
    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = (int'(rr_ptr_q) + k) % N_REQ;
            if (!found && bus.req[IW'(cand)]) begin
                found = 1'b1;
                pick  = IW'(cand);
            end
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        pick_wr    = 1'b0;
        pick_addr  = '0;
        pick_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick == IW'(i)) begin
                pick_wr    = bus.wr[i];
                pick_addr  = bus.addr[i*AW +: AW];
                pick_wdata = bus.wdata[i*DW +: DW];
            end
        end
    end

    // Bank read mux for the latched address.
    always_comb begin
        rd_sel = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (addr_q == AW'(j)) rd_sel = ff_q[j*DW +: DW];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next state and output decode; outputs depend only on registered state.
    always_comb begin
        state_d = state_q;
        bus.gnt = '0;
        bus.ack = '0;
        bus.err = 1'b0;
        ff_en   = '0;
        ff_d    = '0;
        ff_clr  = 1'b0;
        clr_ack = 1'b0;
        busy    = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (clr_req)    state_d = CLEAR;
                else if (found) state_d = ACCESS;
            end
            ACCESS: begin
                state_d = RESP;
                for (int i = 0; i < N_REQ; i++) bus.gnt[i] = (idx_q == IW'(i));
                if (wr_q && in_range) begin
                    for (int j = 0; j < DEPTH; j++) ff_en[j] = (addr_q == AW'(j));
                    ff_d = wdata_q;
                end
            end
            RESP: begin
                state_d = IDLE;
                for (int i = 0; i < N_REQ; i++) begin
                    bus.gnt[i] = (idx_q == IW'(i));
                    bus.ack[i] = (idx_q == IW'(i));
                end
                bus.err = err_q;
            end
            CLEAR: begin
                state_d = IDLE;
                ff_clr  = 1'b1;
                clr_ack = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    // Transaction latches, read capture and round-robin pointer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q    <= '0;
            rr_ptr_q <= IW'(N_REQ - 1);
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!clr_req && found) begin
                        idx_q   <= pick;
                        wr_q    <= pick_wr;
                        addr_q  <= pick_addr;
                        wdata_q <= pick_wdata;
                    end
                end
                ACCESS: begin
                    err_q <= !in_range;
                    if (!wr_q && in_range) rdata_q <= rd_sel;
                end
                RESP:    rr_ptr_q <= idx_q;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ff_bank_arbiter.sv
// Bench for ff_bank_arbiter: a flop bank on the ff_* side, a transaction-level
// reference model checked every cycle, and directed scenarios with literal
// expectations.
module tb_ff_bank_arbiter;
    localparam int N_REQ = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 12;
    localparam int AW    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_req = 1'b0;
    logic clr_ack, busy, ff_clr;
    logic [DEPTH-1:0]    ff_en;
    logic [DW-1:0]       ff_d;
    logic [DEPTH*DW-1:0] bank_q = '0;

    int n_chk  = 0;
    int n_pass = 0;

    ff_bank_arbiter_if #(.N_REQ(N_REQ), .DW(DW), .AW(AW)) bus ();

    ff_bank_arbiter #(.N_REQ(N_REQ), .DW(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .clr_req(clr_req),
        .clr_ack(clr_ack),
        .busy   (busy),
        .ff_en  (ff_en),
        .ff_d   (ff_d),
        .ff_clr (ff_clr),
        .ff_q   (bank_q)
    );

    always #5 clk = ~clk;

    // The flop bank itself (no reset of its own).
    always @(posedge clk) begin
        if (ff_clr) bank_q <= '0;
        else begin
            for (int j = 0; j < DEPTH; j++)
                if (ff_en[j]) bank_q[j*DW +: DW] <= ff_d;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    task automatic timeout_fail(input string name);
        n_chk++;
        $display("FAIL %s: no response within cycle budget", name);
    endtask

    // ---------------- reference model ----------------
    // m_phase: 0 waiting, 1 bank access, 2 response, 3 clearing
    int            m_phase = 0;
    int            m_who   = 0;
    int            m_last  = N_REQ - 1;
    bit            m_wr    = 1'b0;
    int            m_addr  = 0;
    logic [DW-1:0] m_wdata = '0;
    logic [DW-1:0] m_rdata = '0;
    bit            m_err   = 1'b0;
    int            m_c     = 0;
    logic [DW-1:0] mbank [DEPTH] = '{default: '0};

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_phase = 0;
            m_last  = N_REQ - 1;
            m_rdata = '0;
            m_err   = 1'b0;
        end else begin
            case (m_phase)
                0: begin
                    if (clr_req) m_phase = 3;
                    else begin
                        for (int k = 1; k <= N_REQ; k++) begin
                            m_c = (m_last + k) % N_REQ;
                            if (m_phase == 0 && bus.req[m_c]) begin
                                m_who   = m_c;
                                m_wr    = bus.wr[m_c];
                                m_addr  = int'(bus.addr[m_c*AW +: AW]);
                                m_wdata = bus.wdata[m_c*DW +: DW];
                                m_phase = 1;
                            end
                        end
                    end
                end
                1: begin
                    m_err = (m_addr >= DEPTH);
                    if (!m_err) begin
                        if (m_wr) mbank[m_addr] = m_wdata;
                        else      m_rdata = mbank[m_addr];
                    end
                    m_phase = 2;
                end
                2: begin
                    m_last  = m_who;
                    m_phase = 0;
                end
                default: begin
                    for (int j = 0; j < DEPTH; j++) mbank[j] = '0;
                    m_phase = 0;
                end
            endcase
        end
    end

    logic [N_REQ-1:0] e_gnt, e_ack;
    logic [DEPTH-1:0] e_en;
    logic [DW-1:0]    e_d;

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst) begin
            e_gnt = '0; e_ack = '0; e_en = '0; e_d = '0;
            if (m_phase == 1 || m_phase == 2) e_gnt[m_who] = 1'b1;
            if (m_phase == 2) e_ack[m_who] = 1'b1;
            if (m_phase == 1 && m_wr && m_addr < DEPTH) begin
                e_en[m_addr] = 1'b1;
                e_d = m_wdata;
            end
            chk("gnt", bus.gnt, e_gnt);
            chk("ack", bus.ack, e_ack);
            chk("err", bus.err, (m_phase == 2) && m_err);
            chk("rdata", bus.rdata, m_rdata);
            chk("ff_en", ff_en, e_en);
            chk("ff_d", ff_d, e_d);
            chk("ff_clr", ff_clr, m_phase == 3);
            chk("clr_ack", clr_ack, m_phase == 3);
            chk("busy", busy, m_phase != 0);
            for (int j = 0; j < DEPTH; j++)
                chk($sformatf("bank%0d", j), bank_q[j*DW +: DW], mbank[j]);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic wait_ack(input int i, input string name, output int lat,
                            output logic [DEPTH-1:0] en_seen, output logic [DW-1:0] d_seen,
                            output logic [DW-1:0] rd, output logic er);
        bit got = 1'b0;
        lat = 0; en_seen = '0; d_seen = '0; rd = '0; er = 1'b0;
        for (int c = 1; c <= 12 && !got; c++) begin
            @(negedge clk);
            en_seen |= ff_en;
            if (ff_en != '0) d_seen = ff_d;
            if (bus.ack[i]) begin
                got = 1'b1; lat = c; rd = bus.rdata; er = bus.err;
                bus.req[i] = 1'b0;
            end
        end
        if (!got) begin
            timeout_fail(name);
            bus.req[i] = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input bit w, input int a, input int d);
        bus.wr[i] = w;
        bus.addr[i*AW +: AW] = AW'(a);
        bus.wdata[i*DW +: DW] = DW'(d);
        bus.req[i] = 1'b1;
    endtask

    task automatic txn(input int i, input bit w, input int a, input int d, input string name,
                       output int lat, output logic [DEPTH-1:0] en_seen, output logic [DW-1:0] d_seen,
                       output logic [DW-1:0] rd, output logic er);
        @(negedge clk);
        set_req(i, w, a, d);
        wait_ack(i, name, lat, en_seen, d_seen, rd, er);
    endtask

    int rr_exp [5] = '{0, 1, 2, 3, 0};

    initial begin
        int lat, cnt;
        logic [DEPTH-1:0] en;
        logic [DW-1:0] ds, rd;
        logic er;
        logic [DEPTH*DW-1:0] snap;
        logic [N_REQ-1:0] raise, first_ack;
        int order[$];
        bit seen;

        bus.req = '0; bus.wr = '0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", bus.gnt, 0);
        chk("rst_ack", bus.ack, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ff_en", ff_en, 0);
        chk("rst_ff_clr", ff_clr, 0);
        chk("rst_rdata", bus.rdata, 0);
        #1 rst = 1'b1;
        repeat (2) @(negedge clk);

        // single write then read-back
        txn(0, 1'b1, 5, 'hA5, "wr0_timeout", lat, en, ds, rd, er);
        chk("wr_latency", lat, 2);
        chk("wr_ff_en", en, 12'h020);
        chk("wr_ff_d", ds, 8'hA5);
        chk("wr_err", er, 0);
        chk("wr_bank5", bank_q[5*DW +: DW], 8'hA5);
        txn(2, 1'b0, 5, 0, "rd2_timeout", lat, en, ds, rd, er);
        chk("rd_latency", lat, 2);
        chk("rd_rdata", rd, 8'hA5);
        chk("rd_ff_en", en, 0);

        // round-robin with all requesters busy
        @(negedge clk); #1 rst = 1'b0;
        @(negedge clk); #1 rst = 1'b1;
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) set_req(i, 1'b0, i, 0);
        raise = '0;
        for (int c = 0; c < 80 && order.size() < 5; c++) begin
            @(negedge clk);
            bus.req |= raise;
            raise = '0;
            if (bus.ack != '0) begin
                for (int i = 0; i < N_REQ; i++) if (bus.ack[i]) order.push_back(i);
                raise = bus.ack;
                bus.req &= ~bus.ack;
            end
        end
        bus.req = '0;
        if (order.size() < 5) timeout_fail("rr_order_timeout");
        else for (int k = 0; k < 5; k++) chk($sformatf("rr_grant%0d", k), order[k], rr_exp[k]);

        // out-of-range write, and last valid address
        snap = bank_q;
        txn(1, 1'b1, 12, 'hFF, "oor_timeout", lat, en, ds, rd, er);
        chk("oor_ff_en", en, 0);
        chk("oor_err", er, 1);
        chk("oor_bank_same", bank_q == snap, 1);
        txn(1, 1'b1, 11, 'h5A, "top_timeout", lat, en, ds, rd, er);
        chk("top_ff_en", en, 12'h800);
        chk("top_err", er, 0);

        // clear beats a simultaneous request
        @(negedge clk);
        clr_req = 1'b1;
        set_req(3, 1'b0, 5, 0);
        @(negedge clk);
        chk("clr_ff_clr", ff_clr, 1);
        chk("clr_ack", clr_ack, 1);
        chk("clr_gnt", bus.gnt, 0);
        clr_req = 1'b0;
        @(negedge clk);
        chk("clr_bank_zero", bank_q == '0, 1);
        @(negedge clk);
        chk("clr_then_gnt3", bus.gnt, 4'b1000);
        wait_ack(3, "clr_rd3_timeout", lat, en, ds, rd, er);
        chk("clr_rd3_lat", lat, 1);
        chk("clr_rd3_rdata", rd, 0);

        // held clear repeats every two cycles
        @(negedge clk);
        clr_req = 1'b1;
        cnt = 0;
        repeat (6) begin
            @(negedge clk);
            if (clr_ack) cnt++;
        end
        clr_req = 1'b0;
        chk("held_clr_count", cnt, 3);

        // async reset in the middle of a write
        @(negedge clk);
        set_req(1, 1'b1, 3, 'h3C);
        seen = 1'b0;
        for (int c = 0; c < 6 && !seen; c++) begin
            @(negedge clk);
            if (ff_en != '0) seen = 1'b1;
        end
        if (!seen) timeout_fail("abort_access_timeout");
        #2 rst = 1'b0;
        #1;
        chk("abort_ff_en", ff_en, 0);
        chk("abort_ff_d", ff_d, 0);
        chk("abort_gnt", bus.gnt, 0);
        chk("abort_busy", busy, 0);
        bus.req[1] = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b1;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ack != '0) cnt++;
        end
        chk("abort_no_ack", cnt, 0);
        chk("abort_bank3", bank_q[3*DW +: DW], 0);
        set_req(0, 1'b0, 3, 0);
        set_req(1, 1'b0, 3, 0);
        first_ack = '0;
        for (int c = 0; c < 10 && first_ack == '0; c++) begin
            @(negedge clk);
            first_ack = bus.ack;
        end
        bus.req[0] = 1'b0;
        chk("post_rst_first", first_ack, 4'b0001);
        wait_ack(1, "post_rst_rd1_timeout", lat, en, ds, rd, er);
        chk("post_rst_rd1_lat", lat, 3);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
